// File: rtl/nway_cache_pkg.sv
// nway_cache_pkg: shared FSM state encoding, request direction codes and default geometry.
package nway_cache_pkg;
    typedef enum logic [1:0] {INIT, COMPARE, WRITE_BACK, ALLOCATE} state_t;
    localparam logic RW_READ = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    localparam int DEF_WAYS = 4;
    localparam int DEF_INDEX_W = 10;
    localparam int DEF_TAG_W = 10;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/cache_way_ram.sv
// cache_way_ram: one way's line store of {valid, dirty, age, tag, data}; write-first synchronous read.
module cache_way_ram
    import nway_cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int AGE_W = 2,
    parameter int TAG_W = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int W = 2 + AGE_W + TAG_W + DATA_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [W-1:0]       wdata,
    input  logic [INDEX_W-1:0] raddr,
    output logic [W-1:0]       rdata
);
    logic [W-1:0] mem [2**INDEX_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/nway_cache_controller.sv
// nway_cache_controller: N-way write-back/write-allocate cache with true-LRU ages and reset sweep.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module nway_cache_controller
    import nway_cache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int ADDR_W = TAG_W + INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              mem_ready
);
    localparam int AGE_W = $clog2(WAYS);
    localparam int ENT_W = 2 + AGE_W + TAG_W + DATA_W;

    state_t state, state_n;
    logic [INDEX_W-1:0] init_idx, ridx, widx, req_idx;
    logic [TAG_W-1:0] req_tag;
    logic req_valid, req_rw, refill, we, lookup, hit, accept;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [AGE_W-1:0] hit_way, victim, victim_q;
    logic [ENT_W-1:0] rd [WAYS];
    logic [ENT_W-1:0] wr [WAYS];
    logic vld [WAYS];
    logic dty [WAYS];
    logic [AGE_W-1:0] age [WAYS];
    logic [TAG_W-1:0] tag [WAYS];
    logic [DATA_W-1:0] dat [WAYS];

    assign req_tag = req_addr[ADDR_W-1:INDEX_W];
    assign req_idx = req_addr[INDEX_W-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_ram #(.INDEX_W(INDEX_W), .AGE_W(AGE_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_ram (
            .clk(clk), .we(we), .waddr(widx), .wdata(wr[w]), .raddr(ridx), .rdata(rd[w])
        );
        assign {vld[w], dty[w], age[w], tag[w], dat[w]} = rd[w];
    end

    // Invalid ways take priority over the oldest line; lowest-numbered invalid wins.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (vld[i] && tag[i] == req_tag) begin
                hit = lookup;
                hit_way = AGE_W'(i);
            end
            if (age[i] == AGE_W'(WAYS - 1)) victim = AGE_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) if (!vld[i]) victim = AGE_W'(i);
    end

    assign lookup = state == COMPARE && req_valid;
    assign cpu_ready = hit;
    assign cpu_stall = state != COMPARE || (req_valid && !hit);
    assign accept = cpu_valid && !cpu_stall;
    assign ridx = cpu_stall ? req_idx : cpu_addr[INDEX_W-1:0];
    assign cpu_rdata = hit ? dat[hit_way] : '0;
    assign mem_valid = state == WRITE_BACK || state == ALLOCATE;
    assign mem_rw = state == WRITE_BACK;
    assign mem_addr = state == WRITE_BACK ? {tag[victim_q], req_idx} : (state == ALLOCATE ? req_addr : '0);
    assign mem_wdata = state == WRITE_BACK ? dat[victim_q] : '0;

    always_comb begin
        state_n = state;
        we = 1'b0;
        widx = req_idx;
        for (int i = 0; i < WAYS; i++) wr[i] = rd[i];
        case (state)
            INIT: begin
                we = 1'b1;
                widx = init_idx;
                for (int i = 0; i < WAYS; i++) wr[i] = {2'b00, AGE_W'(i), TAG_W'(0), DATA_W'(0)};
                state_n = init_idx == '1 ? COMPARE : INIT;
            end
            COMPARE: if (hit) begin
                we = 1'b1;
                for (int i = 0; i < WAYS; i++)
                    wr[i] = {vld[i], dty[i] | (AGE_W'(i) == hit_way && req_rw == RW_WRITE),
                             (AGE_W'(i) == hit_way ? AGE_W'(0) : age[i] + AGE_W'(age[i] < age[hit_way])),
                             tag[i], (AGE_W'(i) == hit_way && req_rw == RW_WRITE ? req_wdata : dat[i])};
            end else if (lookup) state_n = vld[victim] && dty[victim] ? WRITE_BACK : ALLOCATE;
            WRITE_BACK: state_n = mem_ready ? ALLOCATE : WRITE_BACK;
            ALLOCATE: if (mem_ready) begin
                we = 1'b1;
                state_n = COMPARE;
                wr[victim_q] = {2'b10, age[victim_q], req_tag, mem_rdata};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            init_idx <= '0;
            req_valid <= 1'b0;
            refill <= 1'b0;
        end else begin
            state <= state_n;
            init_idx <= init_idx + INDEX_W'(state == INIT);
            req_valid <= accept || (req_valid && !hit);
            refill <= state == ALLOCATE || (refill && !hit);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_rw <= cpu_rw;
            req_addr <= cpu_addr;
            req_wdata <= cpu_wdata;
        end
        if (lookup && !hit) victim_q <= victim;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            if (hit && !refill && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (lookup && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_nway_cache_controller.sv
// tb_nway_cache_controller: randomized scoreboard bench with a recency-stamp LRU model and a memory responder.
module tb_nway_cache_controller;
    logic clk = 1'b0, rst = 1'b0, cpu_valid = 1'b0, cpu_rw = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata = '0;
    logic cpu_ready, cpu_stall, mem_valid, mem_rw, mem_ready = 1'b0;
    logic [9:0] mem_addr;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    nway_cache_controller #(.WAYS(4), .INDEX_W(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_ready(mem_ready)
    );

    typedef struct { logic rw; logic [31:0] data; logic hit; int acc; } cpu_exp_t;
    typedef struct { logic rw; logic [9:0] addr; logic [31:0] data; } mem_exp_t;
    cpu_exp_t exp_cpu[$];
    mem_exp_t exp_mem[$];
    logic [31:0] ref_mem [1024];
    logic [31:0] mem_arr [1024];
    logic mv [16][4];
    logic md [16][4];
    logic [5:0] mt [16][4];
    int stamp [16][4];
    int now_t, cyc = 0, checks = 0, errors = 0;
    logic mem_hold = 1'b0, wb_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bail(input string name);
        errors++;
        $display("FAIL %s: got no DUT event within the cycle budget, expected one", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Cache contents are only tags/valid/dirty plus a recency stamp; data comes from ref_mem.
    task automatic model_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mt[s][w] = '0;
                stamp[s][w] = -w;
            end
        now_t = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_arr[i];
    endtask

    task automatic issue(input logic rw, input logic [9:0] addr, input logic [31:0] wd, output int waited);
        int idx, way;
        logic h;
        cpu_valid = 1'b1;
        cpu_rw = rw;
        cpu_addr = addr;
        cpu_wdata = wd;
        waited = 0;
        while (cpu_stall) begin
            @(negedge clk);
            waited++;
            if (waited > 400) bail("accept_timeout");
        end
        idx = int'(addr[3:0]);
        h = 1'b0;
        way = -1;
        for (int w = 0; w < 4; w++) if (mv[idx][w] && mt[idx][w] == addr[9:4]) begin h = 1'b1; way = w; end
        if (!h) begin
            for (int w = 0; w < 4; w++) if (!mv[idx][w] && way < 0) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < 4; w++) if (stamp[idx][w] < stamp[idx][way]) way = w;
            end
            if (mv[idx][way] && md[idx][way])
                exp_mem.push_back('{1'b1, {mt[idx][way], addr[3:0]}, ref_mem[{mt[idx][way], addr[3:0]}]});
            exp_mem.push_back('{1'b0, addr, 32'h0});
            mv[idx][way] = 1'b1;
            mt[idx][way] = addr[9:4];
            md[idx][way] = 1'b0;
        end
        if (rw) begin
            ref_mem[addr] = wd;
            md[idx][way] = 1'b1;
        end
        now_t++;
        stamp[idx][way] = now_t;
        exp_cpu.push_back('{rw, ref_mem[addr], h, cyc});
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_cpu.size() != 0 || exp_mem.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) bail("drain_timeout");
        end
    endtask

    task automatic release_and_count();
        int n = 0;
        rst = 1'b1;
        while (cpu_stall) begin
            n++;
            @(negedge clk);
            if (n > 100) bail("init_timeout");
        end
        chk("init_stall_cycles", 64'(n), 64'd16);
    endtask

    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                if (exp_cpu.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got cpu_ready=1, expected 0 with nothing outstanding");
                end else begin
                    e = exp_cpu.pop_front();
                    if (!e.rw) chk("read_data", 64'(cpu_rdata), 64'(e.data));
                    if (e.hit) chk("hit_latency", 64'(cyc - e.acc), 64'd1);
                    else chk("miss_went_to_memory", 64'(cyc - e.acc > 1), 64'd1);
                end
            end
        end
    end

    initial begin
        int wcnt;
        logic [9:0] ca;
        logic c_rw, stable;
        logic [31:0] cw;
        mem_exp_t m;
        wcnt = -1;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!(rst && mem_valid) || (mem_hold && !mem_rw)) wcnt = -1;
            else begin
                if (wcnt < 0) begin
                    wcnt = $urandom_range(0, 3);
                    ca = mem_addr;
                    c_rw = mem_rw;
                    cw = mem_wdata;
                    stable = 1'b1;
                end else if ({mem_addr, mem_rw, mem_wdata} !== {ca, c_rw, cw}) stable = 1'b0;
                if (wcnt == 0) begin
                    chk("mem_req_stable", 64'(stable), 64'd1);
                    if (exp_mem.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem: got mem_valid rw=%0d addr=0x%0h, expected none", mem_rw, mem_addr);
                    end else begin
                        m = exp_mem.pop_front();
                        chk("mem_rw", 64'(mem_rw), 64'(m.rw));
                        chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                        if (m.rw) chk("wb_data", 64'(mem_wdata), 64'(m.data));
                    end
                    if (mem_rw) begin
                        mem_arr[mem_addr] = mem_wdata;
                        if (mem_addr == 10'h013 && mem_wdata == 32'h55) wb_seen = 1'b1;
                    end else mem_rdata = mem_arr[mem_addr];
                    mem_ready = 1'b1;
                    wcnt = -1;
                end else wcnt--;
            end
        end
    end

    initial begin
        #500000;
        bail("global_timeout");
    end

    initial begin
        int w, w1;
        for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
        mem_arr[10'h013] = 32'hDEADBEEF;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({cpu_ready, mem_valid, mem_rw, mem_addr}), 64'd0);
        chk("reset_data", {cpu_rdata, mem_wdata}, 64'd0);
        chk("reset_stall", 64'(cpu_stall), 64'd1);
        release_and_count();

        issue(1'b0, 10'h013, 32'h0, w);
        drain();
        issue(1'b0, 10'h013, 32'h0, w);
        drain();

        for (int t = 1; t <= 4; t++) issue(1'b0, {6'(t), 4'h3}, 32'h0, w);
        issue(1'b0, {6'd1, 4'h3}, 32'h0, w);
        issue(1'b0, {6'd5, 4'h3}, 32'h0, w);
        issue(1'b0, {6'd1, 4'h3}, 32'h0, w);
        issue(1'b0, {6'd2, 4'h3}, 32'h0, w);
        drain();

        issue(1'b1, 10'h013, 32'h55, w);
        for (int t = 6; t <= 9; t++) issue(1'b0, {6'(t), 4'h3}, 32'h0, w);
        drain();
        chk("dirty_evict_wb_seen", 64'(wb_seen), 64'd1);

        issue(1'b1, {6'd9, 4'h3}, 32'hA5, w1);
        issue(1'b0, {6'd9, 4'h3}, 32'h0, w);
        chk("b2b_write_no_stall", 64'(w1), 64'd0);
        chk("b2b_read_no_stall", 64'(w), 64'd0);
        drain();

        repeat (300) begin
            issue(1'($urandom_range(0, 1)), {3'b000, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom_range(0, 3))},
                  $urandom, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        issue(1'b0, {6'h2A, 4'h5}, 32'h0, w);
        drain();
        mem_hold = 1'b1;
        issue(1'b0, {6'h2B, 4'h6}, 32'h0, w);
        w = 0;
        while (!(mem_valid && !mem_rw)) begin
            @(negedge clk);
            w++;
            if (w > 50) bail("allocate_wait");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_valid", 64'(mem_valid), 64'd0);
        exp_cpu.delete();
        exp_mem.delete();
        model_reset();
        mem_hold = 1'b0;
`ifdef CACHE_STATS_EN
        chk("stats_reset", {hit_count, miss_count}, 64'd0);
`endif
        release_and_count();

        issue(1'b0, {6'h2A, 4'h5}, 32'h0, w);
        issue(1'b0, {6'h2A, 4'h5}, 32'h0, w);
        issue(1'b0, {6'h2C, 4'h7}, 32'h0, w);
        issue(1'b0, {6'h2C, 4'h7}, 32'h0, w);
        issue(1'b0, {6'h2A, 4'h5}, 32'h0, w);
        drain();
`ifdef CACHE_STATS_EN
        chk("hit_count", 64'(hit_count), 64'd3);
        chk("miss_count", 64'(miss_count), 64'd2);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
